ring_step_ctrl: RTL

- Upstream control stage for the 13-position rotating one-cold ring and segment decoder.
- Turns raw push-button inputs into the ring's two controls:
  - a single-cycle step enable, which gates the ring's clock enable;
  - a registered direction level.
- Adds input synchronisation, debouncing, run/pause toggling, single-step and a selectable step rate, so the ring advances at a visible rate instead of every clock.

---
 rtl/ring_step_ctrl_if.sv | 21 ++
 rtl/ring_step_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/ring_step_ctrl_if.sv
// Control bundle between the push-button front panel and the ring stepping logic.
// step is a one-cycle strobe with no back-pressure: the ring must take every pulse.
interface ring_step_ctrl_if;
   logic       btn_run_raw;
   logic       btn_step_raw;
   logic       sw_dir_raw;
   logic [1:0] rate_sel;
   logic       step;
   logic       dir;
   logic       running;

   modport master (
      output btn_run_raw, btn_step_raw, sw_dir_raw, rate_sel,
      input  step, dir, running
   );

   modport slave (
      input  btn_run_raw, btn_step_raw, sw_dir_raw, rate_sel,
      output step, dir, running
   );
endinterface

// File: rtl/ring_step_ctrl.sv
// Turns raw buttons into a rate-controlled one-cycle step strobe and a debounced
// direction level for the 13-position one-cold ring.
module ring_step_ctrl #(
   parameter int BASE_DIV  = 1562500,
   parameter int DB_CYCLES = 250000
) (
   input logic             clk,
   input logic             rst,
   ring_step_ctrl_if.slave bus
);
   localparam int PSW = $clog2(8 * BASE_DIV);
   localparam int DBW = $clog2(DB_CYCLES);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [PSW:0]   BASE_P  = (PSW + 1)'(BASE_DIV);

   // Bit 0 = run button, bit 1 = step button, bit 2 = direction switch.
   logic [2:0]     w_raw;
   logic [2:0]     r_sync1;
   logic [2:0]     r_sync2;
   logic [2:0]     r_db;
   logic [DBW-1:0] r_db_cnt [3];
   logic [1:0]     r_db_d;
   logic           r_running;
   logic           r_step;
   logic           r_dir;
   logic [PSW-1:0] r_cnt;
   logic [PSW:0]   w_period;
   logic           w_tick;
   logic           w_rise_run;
   logic           w_rise_step;

   assign w_raw = {bus.sw_dir_raw, bus.btn_step_raw, bus.btn_run_raw};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // db only moves after DB_CYCLES consecutive cycles of disagreement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db <= '0;
         for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db[i]     <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_db_d <= '0;
      else     r_db_d <= r_db[1:0];
   end

   assign w_rise_run  = r_db[0] & ~r_db_d[0];
   assign w_rise_step = r_db[1] & ~r_db_d[1];

   // >= rather than == so a shorter period takes effect at once instead of wrapping.
   assign w_period = BASE_P << (2'd3 - bus.rate_sel);
   assign w_tick   = r_running && ({1'b0, r_cnt} >= (w_period - (PSW + 1)'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_cnt <= '0;
      else if (!r_running) r_cnt <= '0;
      else if (w_tick)     r_cnt <= '0;
      else                 r_cnt <= r_cnt + PSW'(1);
   end

   // A stop press wins over a coincident tick; single-step only acts while paused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_running <= 1'b0;
         r_step    <= 1'b0;
         r_dir     <= 1'b0;
      end else begin
         r_running <= r_running ^ w_rise_run;
         r_step    <= (w_tick & r_running & ~w_rise_run) | (w_rise_step & ~r_running);
         r_dir     <= r_db[2];
      end
   end

   assign bus.step    = r_step;
   assign bus.dir     = r_dir;
   assign bus.running = r_running;
endmodule
